// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
// The control unit drives start/op/operands and the HI/LO writes; the unit returns status and HI/LO.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and restoring divide with the architectural HI/LO registers.
// Operands are reduced to magnitudes at start, iterated WIDTH times, then sign-corrected on the FIX edge.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned RW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state, state_d;
    logic [PW-1:0]    prod, prod_d;
    logic [WIDTH:0]   rem, rem_d;
    logic [WIDTH-1:0] quot, quot_d;
    logic [WIDTH-1:0] opnd, opnd_d;
    logic [WIDTH-1:0] hi, hi_d;
    logic [WIDTH-1:0] lo, lo_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             is_div, is_div_d;
    logic             neg_q, neg_q_d;
    logic             neg_r, neg_r_d;
    logic             busy, busy_d;
    logic             done, done_d;
    logic             div_zero, div_zero_d;

    logic             op_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [RW-1:0]    rem_sh;
    logic [RW-1:0]    div_diff;

    // Magnitudes for signed ops; the most-negative value maps to 2^(WIDTH-1) unsigned.
    assign op_signed = ~bus.op[0];
    assign a_mag     = (op_signed && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_mag     = (op_signed && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

    // One shift-add step and one restoring-divide step.
    assign mul_sum  = {1'b0, prod[PW-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign rem_sh   = {rem, quot[WIDTH-1]};
    assign div_diff = rem_sh - {2'b00, opnd};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        prod_d     = prod;
        rem_d      = rem;
        quot_d     = quot;
        opnd_d     = opnd;
        hi_d       = hi;
        lo_d       = lo;
        cnt_d      = cnt;
        is_div_d   = is_div;
        neg_q_d    = neg_q;
        neg_r_d    = neg_r;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op[1] && (bus.b == '0)) begin
                        hi_d       = bus.a;
                        lo_d       = '1;
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        is_div_d = bus.op[1];
                        neg_q_d  = op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r_d  = op_signed & bus.a[WIDTH-1];
                        opnd_d   = b_mag;
                        prod_d   = {{WIDTH{1'b0}}, a_mag};
                        rem_d    = '0;
                        quot_d   = a_mag;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = RUN;
                    end
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            RUN: begin
                cnt_d = cnt - CNT_W'(1);
                if (is_div) begin
                    if (div_diff[RW-1]) begin
                        rem_d  = rem_sh[WIDTH:0];
                        quot_d = {quot[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_d  = div_diff[WIDTH:0];
                        quot_d = {quot[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    prod_d = {mul_sum, prod[WIDTH-1:1]};
                end
                if (cnt == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                if (is_div) begin
                    lo_d = neg_q ? (~quot + WIDTH'(1)) : quot;
                    hi_d = neg_r ? (~rem[WIDTH-1:0] + WIDTH'(1)) : rem[WIDTH-1:0];
                end else begin
                    {hi_d, lo_d} = neg_q ? (~prod + PW'(1)) : prod;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d != IDLE);

    // Datapath and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod     <= '0;
            rem      <= '0;
            quot     <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            prod     <= prod_d;
            rem      <= rem_d;
            quot     <= quot_d;
            opnd     <= opnd_d;
            hi       <= hi_d;
            lo       <= lo_d;
            cnt      <= cnt_d;
            is_div   <= is_div_d;
            neg_q    <= neg_q_d;
            neg_r    <= neg_r_d;
            busy     <= busy_d;
            done     <= done_d;
            div_zero <= div_zero_d;
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.div_zero = div_zero;
    assign bus.hi       = hi;
    assign bus.lo       = lo;
endmodule
